// File: rtl/wbu_commit.sv
// Write-back/commit stage: captures one retired instruction from the LSU, commits it
// to the architectural register file, PC and retire counter, then offers the PC to fetch.
module wbu_commit #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int unsigned CNT_W    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wbu_valid,
    output logic             wbu_ready,
    input  logic [31:0]      Next_pc,
    input  logic [4:0]       Rw,
    input  logic [31:0]      result,
    input  logic             regwr,
    output logic             ifu_valid,
    input  logic             ifu_ready,
    output logic [31:0]      pc_out,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [31:0]      rdata1,
    output logic [31:0]      rdata2,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [1:0] BOOT          = 2'd0;
    localparam logic [1:0] WAIT_WBUVALID = 2'd1;
    localparam logic [1:0] COMMIT        = 2'd2;
    localparam logic [1:0] WAIT_IFUREADY = 2'd3;

    logic [1:0]  state;
    logic [31:0] lat_pc;
    logic [4:0]  lat_rw;
    logic [31:0] lat_result;
    logic        lat_regwr;
    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc_out     <= RESET_PC;
            retire_cnt <= '0;
            lat_pc     <= '0;
            lat_rw     <= '0;
            lat_result <= '0;
            lat_regwr  <= 1'b0;
            regs       <= '{default: '0};
        end else begin
            case (state)
                BOOT: begin
                    if (ifu_ready) state <= WAIT_WBUVALID;
                end
                WAIT_WBUVALID: begin
                    if (wbu_valid) begin
                        lat_pc     <= Next_pc;
                        lat_rw     <= Rw;
                        lat_result <= result;
                        lat_regwr  <= regwr;
                        state      <= COMMIT;
                    end
                end
                COMMIT: begin
                    // x0 is hardwired to zero, so its writes are dropped here
                    if (lat_regwr && (lat_rw != 5'd0)) regs[lat_rw] <= lat_result;
                    pc_out     <= lat_pc;
                    retire_cnt <= retire_cnt + CNT_W'(1);
                    state      <= WAIT_IFUREADY;
                end
                WAIT_IFUREADY: begin
                    if (ifu_ready) state <= WAIT_WBUVALID;
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign wbu_ready = (state == WAIT_WBUVALID);
    assign ifu_valid = (state == BOOT) || (state == WAIT_IFUREADY);

    // Reads see the committed file only; a same-cycle COMMIT write is not bypassed
    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: tb/tb_wbu_commit.sv
// Randomized bench for wbu_commit: a transaction-level model of the architectural
// state (registers, PC, retire count) is checked against the DUT every cycle.
module tb_wbu_commit;

    localparam logic [31:0] RST_PC = 32'h80000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbu_valid;
    logic        wbu_ready;
    logic [31:0] Next_pc;
    logic [4:0]  Rw;
    logic [31:0] result;
    logic        regwr;
    logic        ifu_valid;
    logic        ifu_ready;
    logic [31:0] pc_out;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [63:0] retire_cnt;

    always #5 clk = ~clk;

    wbu_commit #(.RESET_PC(RST_PC), .CNT_W(64)) dut (
        .clk(clk), .reset(reset),
        .wbu_valid(wbu_valid), .wbu_ready(wbu_ready),
        .Next_pc(Next_pc), .Rw(Rw), .result(result), .regwr(regwr),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .pc_out(pc_out),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .retire_cnt(retire_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [63:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc  = RST_PC;
        m_cnt = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic garbage();
        Next_pc = $urandom;
        Rw      = 5'($urandom);
        result  = $urandom;
        regwr   = 1'($urandom);
    endtask

    // Handshake flags, architectural PC/count and a random read port-2 probe
    task automatic chk_state(input string tag, input logic exp_wr, input logic exp_iv);
        logic [4:0] a;
        check({tag, ".wbu_ready"}, 64'(wbu_ready), 64'(exp_wr));
        check({tag, ".ifu_valid"}, 64'(ifu_valid), 64'(exp_iv));
        check({tag, ".pc_out"}, 64'(pc_out), 64'(m_pc));
        check({tag, ".retire_cnt"}, retire_cnt, m_cnt);
        a = 5'($urandom_range(0, 31));
        raddr2 = a;
        #1;
        check({tag, ".rdata2"}, 64'(rdata2), 64'(m_regs[a]));
    endtask

    task automatic boot(input int n_wait);
        for (int i = 0; i < n_wait; i++) begin
            ifu_ready = 1'b0;
            wbu_valid = 1'($urandom);
            tick();
            chk_state("boot", 1'b0, 1'b1);
        end
        ifu_ready = 1'b1;
        tick();
        chk_state("boot_exit", 1'b1, 1'b0);
        ifu_ready = 1'b0;
        wbu_valid = 1'b0;
    endtask

    task automatic txn(input logic [31:0] nxt, input logic [4:0] rw, input logic [31:0] res,
                       input logic wr, input int idle, input int hold, input logic noisy);
        for (int i = 0; i < idle; i++) begin
            wbu_valid = 1'b0;
            ifu_ready = 1'($urandom);
            garbage();
            tick();
            chk_state("wait", 1'b1, 1'b0);
        end
        wbu_valid = 1'b1;
        Next_pc = nxt; Rw = rw; result = res; regwr = wr;
        raddr1 = rw;
        ifu_ready = 1'($urandom);
        tick();
        chk_state("commit", 1'b0, 1'b0);
        check("commit.rdata1_old", 64'(rdata1), 64'(m_regs[rw]));
        wbu_valid = noisy ? 1'b1 : 1'($urandom);
        ifu_ready = 1'($urandom);
        garbage();
        tick();
        if (wr && rw != 5'd0) m_regs[rw] = res;
        m_pc  = nxt;
        m_cnt = m_cnt + 64'd1;
        chk_state("offer", 1'b0, 1'b1);
        check("offer.rdata1_new", 64'(rdata1), 64'(m_regs[rw]));
        for (int i = 0; i < hold; i++) begin
            ifu_ready = 1'b0;
            wbu_valid = noisy ? 1'(i & 1) : 1'($urandom);
            garbage();
            tick();
            chk_state("hold", 1'b0, 1'b1);
        end
        ifu_ready = 1'b1;
        wbu_valid = noisy;
        tick();
        chk_state("take", 1'b1, 1'b0);
        ifu_ready = 1'b0;
        wbu_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        wbu_valid = 1'b0; ifu_ready = 1'b0;
        Next_pc = '0; Rw = '0; result = '0; regwr = 1'b0;
        raddr1 = '0; raddr2 = '0;
        model_reset();
        tick();
        chk_state("reset", 1'b0, 1'b1);
        raddr1 = 5'd1;
        #1;
        check("reset.rdata1", 64'(rdata1), 64'd0);

        reset = 1'b1;
        boot(3);

        txn(32'h80000004, 5'd5, 32'hDEADBEEF, 1'b1, 1, 0, 1'b0);
        txn(32'h80000008, 5'd0, 32'h12345678, 1'b1, 0, 0, 1'b0);
        txn(32'h8000000C, 5'd7, 32'hA5A5A5A5, 1'b1, 0, 0, 1'b0);
        txn(32'h80000010, 5'd7, 32'h0BADF00D, 1'b0, 0, 0, 1'b1);
        txn(32'h80000014, 5'd9, 32'h00C0FFEE, 1'b1, 2, 10, 1'b1);

        // Reset asserted while the commit of x3 is in flight
        wbu_valid = 1'b1;
        Next_pc = 32'h80000018; Rw = 5'd3; result = 32'h55; regwr = 1'b1;
        raddr1 = 5'd3;
        tick();
        chk_state("pre_rst_commit", 1'b0, 1'b0);
        wbu_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst.ifu_valid", 64'(ifu_valid), 64'd1);
        check("midrst.wbu_ready", 64'(wbu_ready), 64'd0);
        check("midrst.pc_out", 64'(pc_out), 64'(RST_PC));
        check("midrst.retire_cnt", retire_cnt, 64'd0);
        check("midrst.reg3", 64'(rdata1), 64'd0);
        raddr1 = 5'd5;
        #1;
        check("midrst.reg5", 64'(rdata1), 64'd0);
        tick();
        chk_state("in_reset", 1'b0, 1'b1);
        reset = 1'b1;
        boot(2);

        for (int n = 0; n < 40; n++) begin
            txn($urandom, 5'($urandom), $urandom, 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
